// File: rtl/fmap_hdshk_buffer.sv
// fmap_hdshk_buffer: feature-map buffer, requantising conv write stream, addr/data handshake read responder
// Ports: clk; rst (async, active-low); in_data/in_valid/in_ready write stream;
// full (map complete, reads live); map_release (pulse: map consumed, refill);
// addr/addr_valid/addr_ready read request; data/data_valid/data_ready read response.
module fmap_hdshk_buffer #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10,
  parameter int IN_W   = 32,
  parameter int DATA_W = 8,
  parameter int SHIFT  = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IN_W-1:0]   in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              full,
  input  logic              map_release,
  input  logic [ADDR_W-1:0] addr,
  input  logic              addr_valid,
  output logic              addr_ready,
  output logic [DATA_W-1:0] data,
  output logic              data_valid,
  input  logic              data_ready
);
  typedef enum logic {FILL, SERVE} state_t;
  localparam logic signed [IN_W-1:0] HI = IN_W'(2 ** (DATA_W - 1) - 1);
  localparam logic signed [IN_W-1:0] LO = ~HI;
  state_t state, state_nx;
  logic armed, rel_pend, wr_en, rd_en, go, last;
  logic [ADDR_W-1:0] wr_ptr;
  logic signed [IN_W-1:0] shifted;
  logic [DATA_W-1:0] wr_word;
  logic [DATA_W-1:0] mem [DEPTH];
  assign shifted = $signed(in_data) >>> SHIFT;
  assign wr_word = shifted > HI ? HI[DATA_W-1:0] : shifted < LO ? LO[DATA_W-1:0] : shifted[DATA_W-1:0];
  // armed keeps in_ready low for the first cycle out of reset
  assign in_ready = state == FILL && armed;
  assign full = state == SERVE;
  // a release on the same cycle blocks the address so it cannot race the refill
  assign addr_ready = full && !rel_pend && !map_release && (!data_valid || data_ready);
  assign wr_en = in_valid && in_ready;
  assign rd_en = addr_valid && addr_ready;
  assign last = wr_ptr == ADDR_W'(DEPTH - 1);
  // leave SERVE only once no response is left hanging
  assign go = full && (map_release || rel_pend) && (!data_valid || data_ready);
  always_comb state_nx = (state == FILL && wr_en && last) ? SERVE : go ? FILL : state;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state      <= FILL;
      armed      <= 1'b0;
      wr_ptr     <= '0;
      rel_pend   <= 1'b0;
      data_valid <= 1'b0;
      data       <= '0;
    end else begin
      state    <= state_nx;
      armed    <= 1'b1;
      rel_pend <= full && !go && (rel_pend || map_release);
      if (go) wr_ptr <= '0;
      else if (wr_en) wr_ptr <= last ? '0 : wr_ptr + 1'b1;
      if (rd_en) begin
        data_valid <= 1'b1;
        data       <= int'(addr) < DEPTH ? mem[addr] : '0;
      end else if (data_ready) data_valid <= 1'b0;
    end
  always_ff @(posedge clk)
    if (wr_en) mem[wr_ptr] <= wr_word;
endmodule

// File: doc/fmap_hdshk_buffer.md
Name: fmap_hdshk_buffer

Overview:
- Feature-map buffer between two convolution layers.
- Write side accepts the conv stream (out_data/out_valid style): 32-bit accumulators, requantised to signed 8-bit, stored in raster order.
- Read side is the responder end of the addr/addr_valid/addr_ready + data/data_valid/data_ready handshake that the conv engines issue as initiators, so the next layer reads the map exactly as it reads an image ROM.

Parameters:
- DEPTH, 1024, number of stored pixels (WIDTH*HEIGHT of one feature map).
- ADDR_W, 10, read address width; must satisfy 2^ADDR_W >= DEPTH.
- IN_W, 32, input accumulator width (signed two's complement).
- DATA_W, 8, stored/returned word width (signed).
- SHIFT, 7, arithmetic right shift applied before saturation (fixed-point rescale).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_data  in  IN_W  conv accumulator word.
- in_valid  in  1  in_data valid.
- in_ready  out  1  buffer accepts in_data this cycle.
- full  out  1  all DEPTH words written; read side live.
- release  in  1  one-cycle pulse: map consumed, return to fill.
- addr  in  ADDR_W  read address.
- addr_valid  in  1  read request valid.
- addr_ready  out  1  read request accepted when addr_valid & addr_ready.
- data  out  DATA_W  read data.
- data_valid  out  1  data holds the response.
- data_ready  in  1  initiator takes data when data_valid & data_ready.

Behaviour:
- Reset (rst=0, async): state=FILL, wr_ptr=0, in_ready=0 for the first cycle after deassertion then 1, full=0, addr_ready=0, data_valid=0, data=0, release_pend=0. Memory contents are not reset.
- States:
  - FILL: in_ready=1, addr_ready=0.
  - SERVE: in_ready=0, full=1.
  - FILL->SERVE on the write handshake with wr_ptr==DEPTH-1. full rises the next cycle.
  - SERVE->FILL when release is seen (or pending) and no response is outstanding (data_valid=0, or data handshake completing that cycle). wr_ptr clears to 0 and full drops the next cycle.
- Write arithmetic per accepted word:
  - t = in_data >>> SHIFT (arithmetic shift, truncation toward -inf).
  - Saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; store at mem[wr_ptr]; wr_ptr++.
  - in_valid while in_ready=0 is ignored, with no side effect.
- Read handshake (SERVE only):
  - addr_ready = SERVE & !release_pend & (!data_valid | data_ready).
  - On accept in cycle N: data and data_valid=1 from cycle N+1 (one-cycle sync RAM latency).
  - data and data_valid hold stable until data_ready.
  - A new accept in the same cycle as a data handshake gives back-to-back responses at 1 word/cycle.
  - addr >= DEPTH returns 0 and is still handshaken.
- release:
  - Arriving in FILL is ignored.
  - Arriving in SERVE with a response stalled sets release_pend: addr_ready=0 until the stalled data handshake completes, then transition.
  - Simultaneous release and addr_valid: release wins, the address is not accepted.
- Reset mid-operation aborts everything immediately; any partial map is discarded (wr_ptr=0).

Test Plan:
- Fill DEPTH words with in_data=i<<7 (i=0..1023): mem[i]=sat(i) → reads of addr 5/127/200 return 5/127/127; full=1 exactly one cycle after the 1024th write; in_ready=0 afterwards.
- Saturation/sign: in_data=-200<<7, 0xFFFFFFFF, 0x7FFFFFFF, 300 → stored -128, -1, 127, 2.
- Back-to-back reads with data_ready=1 and addr 0..9 on consecutive cycles: data_valid high 10 consecutive cycles, data 0..9 in order, no bubbles.
- Backpressure: addr=3 accepted, data_ready=0 for 4 cycles: data=3 held stable with data_valid=1, addr_ready=0 throughout; one response only after data_ready.
- release during a stalled response: no new address accepted, FILL entered only the cycle after the data handshake; the next 1024-word fill overwrites the old map correctly.
- rst pulsed low mid-fill after 500 words: all outputs at reset values asynchronously; a subsequent full 1024-word fill asserts full only after 1024 writes.
